// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: ID/EX hazard info, multiply/divide and memory status in; stage enables out.
// Latency: pure wiring, no storage.
// Backpressure: none of its own; the controller answers a stall with write enables held at 0.
interface pipeline_ctrl_if;
    logic [4:0] i_id_rs1;
    logic [4:0] i_id_rs2;
    logic       i_id_use_rs1;
    logic       i_id_use_rs2;
    logic [4:0] i_ex_rd;
    logic       i_ex_memread;
    logic       i_ex_redirect;
    logic       i_ex_is_auipc;
    logic       i_md_start;
    logic       i_md_done;
    logic       i_mem_busy;
    logic       o_pc_we;
    logic       o_if_id_we;
    logic       o_id_ex_we;
    logic       o_ex_mem_we;
    logic       o_if_id_flush;
    logic       o_id_ex_flush;
    logic       o_md_timeout;

    // Core side: drives pipeline status, receives the enables.
    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rd, i_ex_memread,
               i_ex_redirect, i_ex_is_auipc, i_md_start, i_md_done, i_mem_busy,
        input  o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_if_id_flush,
               o_id_ex_flush, o_md_timeout
    );

    // Controller side.
    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rd, i_ex_memread,
               i_ex_redirect, i_ex_is_auipc, i_md_start, i_md_done, i_mem_busy,
        output o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_if_id_flush,
               o_id_ex_flush, o_md_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline hazard/stall controller: load-use stall, redirect flush, MD wait with watchdog, memory wait.
// Latency: enables and flushes are combinational from state and inputs; state advances on i_clk.
// Backpressure: i_mem_busy freezes every stage (highest priority); an MD op freezes until done or timeout.
// Optional: define PIPELINE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipeline_ctrl #(
    parameter int MD_TIMEOUT   = 64,  // 2..255
    parameter int FLUSH_CYCLES = 2    // 1..3
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    pipeline_ctrl_if.slave   bus
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]      o_stall_cnt,
    output logic [31:0]      o_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [7:0] WD_LAST    = 8'(MD_TIMEOUT - 1);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;        // state to resume after a memory wait
    logic [1:0] flush_q, flush_d;    // extra IF/ID flush cycles still owed
    logic [7:0] wd_q, wd_d;          // MD_WAIT watchdog

    logic pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c;
    logic if_id_flush_c, id_ex_flush_c, md_timeout_c, redirect_acc_c;

    logic load_use;
    logic redirect;

    assign load_use = bus.i_ex_memread && (bus.i_ex_rd != 5'd0) &&
                      ((bus.i_id_use_rs1 && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                       (bus.i_id_use_rs2 && (bus.i_id_rs2 == bus.i_ex_rd)));
    assign redirect = bus.i_ex_redirect && !bus.i_ex_is_auipc;

    // State, remembered state, flush counter and watchdog registers.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            flush_q <= 2'd0;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            flush_q <= flush_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state and raw (pre-reset-gating) outputs.
    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        wd_d           = wd_q;
        // A pending flush keeps draining no matter what state we are in.
        flush_d        = (flush_q != 2'd0) ? flush_q - 2'd1 : 2'd0;
        if_id_flush_c  = (flush_q != 2'd0);
        id_ex_flush_c  = 1'b0;
        pc_we_c        = 1'b0;
        if_id_we_c     = 1'b0;
        id_ex_we_c     = 1'b0;
        ex_mem_we_c    = 1'b0;
        md_timeout_c   = 1'b0;
        redirect_acc_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.i_mem_busy) begin
                    state_d = ST_MEM_WAIT;
                    ret_d   = ST_RUN;
                end else if (redirect) begin
                    // Redirect wins over a load-use hazard: the ID instruction is squashed anyway.
                    pc_we_c        = 1'b1;
                    if_id_we_c     = 1'b1;
                    id_ex_we_c     = 1'b1;
                    ex_mem_we_c    = 1'b1;
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    flush_d        = FLUSH_LOAD;
                    redirect_acc_c = 1'b1;
                end else if (bus.i_md_start) begin
                    // Freeze already in the start cycle so the MD instruction stays in EX.
                    state_d = ST_MD_WAIT;
                    wd_d    = 8'd0;
                end else if (load_use) begin
                    id_ex_we_c    = 1'b1;
                    ex_mem_we_c   = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else begin
                    pc_we_c     = 1'b1;
                    if_id_we_c  = 1'b1;
                    id_ex_we_c  = 1'b1;
                    ex_mem_we_c = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (bus.i_mem_busy) begin
                    // Watchdog holds its value while memory stalls us.
                    state_d = ST_MEM_WAIT;
                    ret_d   = ST_MD_WAIT;
                end else if (bus.i_md_done) begin
                    state_d     = ST_RUN;
                    pc_we_c     = 1'b1;
                    if_id_we_c  = 1'b1;
                    id_ex_we_c  = 1'b1;
                    ex_mem_we_c = 1'b1;
                end else if (wd_q >= WD_LAST) begin
                    state_d      = ST_RUN;
                    md_timeout_c = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.i_mem_busy) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Every output is forced low while reset is held.
    assign bus.o_pc_we       = i_resetn && pc_we_c;
    assign bus.o_if_id_we    = i_resetn && if_id_we_c;
    assign bus.o_id_ex_we    = i_resetn && id_ex_we_c;
    assign bus.o_ex_mem_we   = i_resetn && ex_mem_we_c;
    assign bus.o_if_id_flush = i_resetn && if_id_flush_c;
    assign bus.o_id_ex_flush = i_resetn && id_ex_flush_c;
    assign bus.o_md_timeout  = i_resetn && md_timeout_c;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating counts of PC-stalled cycles and accepted redirects.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pc_we_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_acc_c && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule
